apb_master_arbiter: RTL and testbench

Shares one APB3 master port between `N_REQ` local requesters. Each requester posts a single read or write over a req/done handshake. A round-robin arbiter picks one requester, and an IDLE/SETUP/ACCESS state machine sequences the APB3 transfer. The block sits between the testbench or host sequencers and the `apb_if` signal bundle, and drives the same psel/penable/pwrite/paddr/pwdata set that the slave VIP consumes.

---
 rtl/apb_arb_pkg.sv | 14 +
 rtl/apb_rr_arbiter.sv | 35 +++
 rtl/apb_master_arbiter.sv | 144 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and widths for the APB master arbiter
package apb_arb_pkg;

  localparam int APB_AW  = 32;
  localparam int APB_DW  = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_arb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - combinational round-robin pick, search starts at ptr
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt
);

  localparam int PW = $clog2(N_REQ);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // wrap (ptr + i) modulo N_REQ, which need not be a power of two
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - N_REQ requesters sharing one APB3 master port
// Optional ACCESS timeout abort is built when APB_ARB_TIMEOUT_EN is defined.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*APB_AW-1:0] req_addr,
  input  logic [N_REQ*APB_DW-1:0] req_wdata,
  output logic [N_REQ-1:0]        done,
  output logic [APB_DW-1:0]       rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [APB_AW-1:0]       paddr,
  output logic [APB_DW-1:0]       pwdata,
  input  logic [APB_DW-1:0]       prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("apb_master_arbiter: N_REQ must be 2..MAX_REQ and TIMEOUT_CYCLES >= 1");
  end

  apb_arb_state_e    state, state_nx;
  logic [PW-1:0]     ptr, win, ptr_nx, sel_idx;
  logic [N_REQ-1:0]  cand, gnt;
  logic              sel_write, xfer_end, timeout_hit;
  logic [APB_AW-1:0] sel_addr;
  logic [APB_DW-1:0] sel_wdata;
  logic [APB_AW-1:0] addr_arr  [N_REQ];
  logic [APB_DW-1:0] wdata_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*APB_AW +: APB_AW];
    assign wdata_arr[g] = req_wdata[g*APB_DW +: APB_DW];
  end

  // the requester being acknowledged this cycle must not win again immediately
  assign cand = req & ~done;

  apb_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req (cand),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_idx = PW'(i);
    end
  end

  assign sel_write = req_write[sel_idx];
  assign sel_addr  = addr_arr[sel_idx];
  assign sel_wdata = wdata_arr[sel_idx];
  assign ptr_nx    = (win == PW'(N_REQ-1)) ? '0 : win + 1'b1;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !pready) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // fires on the wait cycle that takes the count to TIMEOUT_CYCLES
  assign timeout_hit = (state == ACCESS) && !pready && (tmo_cnt == TW'(TIMEOUT_CYCLES-1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    psel     = 1'b0;
    penable  = 1'b0;
    xfer_end = 1'b0;
    case (state)
      IDLE:    if (|gnt) state_nx = SETUP;
      SETUP: begin
        psel     = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || timeout_hit) begin
          xfer_end = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      win        <= '0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      done       <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      done <= '0;
      if (state == IDLE && |gnt) begin
        win    <= sel_idx;
        pwrite <= sel_write;
        paddr  <= sel_addr;
        pwdata <= sel_wdata;
      end
      if (xfer_end) begin
        done[win]  <= 1'b1;
        rsp_rdata  <= (pwrite || timeout_hit) ? '0 : prdata;
        rsp_slverr <= pslverr | timeout_hit;
        ptr        <= ptr_nx;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - vector table plus scoreboard bench for apb_master_arbiter
module tb_apb_master_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, req_write;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N-1:0]  done;
  logic [31:0]   rsp_rdata;
  logic          rsp_slverr;
  logic          psel, penable, pwrite;
  logic [31:0]   paddr, pwdata;
  logic [31:0]   prdata;
  logic          pready, pslverr;

  apb_master_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else passes++;
  endtask

  // slave model: pready after cfg_waits wait states in ACCESS
  int          cfg_waits = 0;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_err   = 1'b0;
  int          acc_cnt   = 0;

  always @(negedge clk) begin
    if (psel && penable) acc_cnt++;
    else                 acc_cnt = 0;
    pready  = psel && penable && (acc_cnt > cfg_waits);
    prdata  = (psel && penable) ? cfg_rdata : 32'h0;
    pslverr = pready ? cfg_err : 1'b0;
  end

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst && |done) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 32'(done), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_onehot", 32'($onehot(done)), 32'h1);
        chk("done_idx", 32'(done), 32'(1) << mon_e.idx);
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_slverr", 32'(rsp_slverr), 32'(mon_e.err));
      end
    end
  end

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] srd;
    bit          serr;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic run_xfer(input vec_t v, input bit drop_early);
    int t, pen;
    bit seen, stable;
    @(negedge clk);
    req = '0;
    req_write[v.idx] = v.wr;
    req_addr[v.idx*32 +: 32]  = v.addr;
    req_wdata[v.idx*32 +: 32] = v.wdata;
    req[v.idx] = 1'b1;
    cfg_waits = v.waits;
    cfg_rdata = v.srd;
    cfg_err   = v.serr;
    sb.push_back('{v.idx, v.exp_rd, v.exp_err});
    t = 0; pen = 0; seen = 0; stable = 1;
    while (!seen && t < 200) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        chk("setup_psel", 32'(psel), 32'h1);
        chk("setup_penable", 32'(penable), 32'h0);
        chk("setup_paddr", paddr, v.addr);
        chk("setup_pwrite", 32'(pwrite), 32'(v.wr));
        chk("setup_pwdata", pwdata, v.wdata);
        if (drop_early) req[v.idx] = 1'b0;
      end
      if (penable) begin
        pen++;
        if (paddr !== v.addr || pwrite !== v.wr) stable = 0;
      end
      if (done[v.idx]) begin
        seen = 1;
        chk("done_cycle_psel", 32'(psel), 32'h0);
        req[v.idx] = 1'b0;
      end
    end
    chk("done_seen", 32'(seen), 32'h1);
    chk("latency", t, v.exp_lat);
    chk("penable_cycles", pen, v.exp_lat - 2);
    chk("paddr_stable", 32'(stable), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, last;
    vec_t dv;

    //          idx wr addr          wdata         waits srd           serr exp_rd        err lat
    vecs[0] = '{1, 1, 32'h00000010, 32'hDEADBEEF, 0, 32'hAAAA5555, 0, 32'h00000000, 0, 3};
    vecs[1] = '{0, 0, 32'h00000020, 32'h00000000, 3, 32'h12345678, 0, 32'h12345678, 0, 6};
    vecs[2] = '{3, 1, 32'h00000030, 32'hCAFEF00D, 1, 32'h00000000, 1, 32'h00000000, 1, 4};
    vecs[3] = '{2, 0, 32'h00000044, 32'h00000000, 0, 32'h0BADC0DE, 0, 32'h0BADC0DE, 0, 3};
    vecs[4] = '{1, 1, 32'hFFFFFFFC, 32'h00000001, 0, 32'h00000055, 0, 32'h00000000, 0, 3};
    vecs[5] = '{2, 0, 32'h00000048, 32'h00000000, 2, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1, 5};

    rst = 1'b1;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_pwrite", 32'(pwrite), 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_slverr", 32'(rsp_slverr), 32'h0);

    // all four requesters held from reset: grants 0,1,2,3,0 three cycles apart
    for (int i = 0; i < N; i++) req_addr[i*32 +: 32] = 32'h100 + 32'(4*i);
    req = '1;
    cfg_waits = 0; cfg_rdata = 32'hA5A50000; cfg_err = 1'b0;
    sb.push_back('{0, 32'hA5A50000, 1'b0});
    sb.push_back('{1, 32'hA5A50000, 1'b0});
    sb.push_back('{2, 32'hA5A50000, 1'b0});
    sb.push_back('{3, 32'hA5A50000, 1'b0});
    sb.push_back('{0, 32'hA5A50000, 1'b0});
    rst = 1'b0;
    t = 0; n = 0; last = 0;
    while (n < 5 && t < 60) begin
      @(negedge clk);
      t++;
      if (|done) begin
        n++;
        if (n == 1) chk("rr_first_latency", t, 3);
        else        chk("rr_spacing", t - last, 3);
        last = t;
        if (n == 5) req = '0;
      end
    end
    chk("rr_done_count", n, 5);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i], 1'b0);

    // requester drops req during SETUP; transfer still completes
    dv = '{2, 1, 32'h00000060, 32'h0000600D, 0, 32'h0, 0, 32'h0, 0, 3};
    run_xfer(dv, 1'b1);

    // reset in ACCESS with ptr=3: abandon, then ptr must restart at 0
    @(negedge clk);
    req = '0;
    req_write[2] = 1'b0;
    req_addr[64 +: 32] = 32'h70;
    req[2] = 1'b1;
    cfg_waits = 5; cfg_rdata = 32'hDEAD0070; cfg_err = 1'b0;
    t = 0;
    while (!(psel && penable) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reached_access", 32'(psel && penable), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("abort_psel", 32'(psel), 32'h0);
    chk("abort_penable", 32'(penable), 32'h0);
    chk("abort_paddr", paddr, 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (|done) n++;
    end
    chk("abort_no_done", n, 0);

    req_write = '0;
    req_addr[32 +: 32] = 32'h90;
    req_addr[96 +: 32] = 32'h98;
    cfg_waits = 0; cfg_rdata = 32'h00000777; cfg_err = 1'b0;
    sb.push_back('{1, 32'h00000777, 1'b0});
    sb.push_back('{3, 32'h00000777, 1'b0});
    req[1] = 1'b1;
    req[3] = 1'b1;
    t = 0; n = 0;
    while (n < 2 && t < 30) begin
      @(negedge clk);
      t++;
      if (|done) begin
        if (n == 0) chk("ptr_reset_first_grant", 32'(done), 32'h2);
        req = req & ~done;
        n++;
      end
    end
    chk("ptr_reset_done_count", n, 2);

`ifdef APB_ARB_TIMEOUT_EN
    dv = '{0, 0, 32'h00000080, 32'h0, 1000, 32'h0000FFFF, 0, 32'h0, 1, 10};
    run_xfer(dv, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
